// File: rtl/rand_pkg.sv
// Shared types and constants for the shared-LFSR random arbiter.
package rand_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned BITS_W = 5;

  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    RESP    = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [BITS_W-1:0] b;
  } grant_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  // Mask of b+1 low ones; b=31 yields all ones.
  function automatic logic [LFSR_W-1:0] range_mask(input logic [BITS_W-1:0] b);
    return 32'hFFFF_FFFF >> (5'd31 - b);
  endfunction

endpackage

// File: rtl/rand_arbiter_lfsr32_core.sv
// 32-bit Fibonacci LFSR that shifts only on request; a zero seed is replaced so it never locks up.
module lfsr32_core
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_data,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ZERO_SEED_SUB;
    end else if (load) begin
      state <= (load_data == '0) ? ZERO_SEED_SUB : load_data;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out masked draws from one shared LFSR.
// Optional build macro RAND_ZERO_SKIP_EN: keep shifting until the masked draw is non-zero.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned STEPS   = 8
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      seed_load,
  input  logic [LFSR_W-1:0]         seed_data,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BITS_W*NUM_REQ-1:0] req_bits,
  output logic                      ack,
  output logic [ID_W-1:0]           ack_id,
  output logic [LFSR_W-1:0]         rand_out,
  output logic                      busy
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = ID_W + 1;
  localparam int unsigned SH_W  = 6;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  grant_t              grant_q, grant_d;
  logic                ack_d, busy_d;
  logic [ID_W-1:0]     ack_id_d;
  logic [LFSR_W-1:0]   rand_d;

  logic [LFSR_W-1:0]   lfsr_q;
  logic                step_c;
  logic [LFSR_W-1:0]   masked_c;
  logic                reject_c;

  logic [NUM_REQ-1:0]  rot_c;
  logic                win_valid_c;
  logic [ID_W-1:0]     win_off_c;
  logic [SUM_W-1:0]    win_sum_c;
  logic [ID_W-1:0]     win_id_c;
  logic [SH_W-1:0]     bits_sh_c;
  logic [BITS_W-1:0]   win_b_c;
  logic [SUM_W-1:0]    rr_inc_c;

  lfsr32_core u_lfsr (
    .clk       (clk),
    .clr_n     (clr_n),
    .step      (step_c),
    .load      (seed_load),
    .load_data (seed_data),
    .state     (lfsr_q)
  );

  assign masked_c = lfsr_next(lfsr_q) & range_mask(grant_q.b);

`ifdef RAND_ZERO_SKIP_EN
  assign reject_c = (masked_c == '0);
`else
  assign reject_c = 1'b0;
`endif

  // Rotate requests so bit 0 is rr_q, then pick the lowest set bit.
  assign rot_c       = NUM_REQ'({req, req} >> rr_q);
  assign win_valid_c = |rot_c;

  always_comb begin
    win_off_c = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (rot_c[SEL_W'(k)]) win_off_c = ID_W'(k);
    end
    win_sum_c = SUM_W'(rr_q) + SUM_W'(win_off_c);
    if (win_sum_c >= SUM_W'(NUM_REQ)) win_sum_c = win_sum_c - SUM_W'(NUM_REQ);
  end

  assign win_id_c  = ID_W'(win_sum_c);
  assign bits_sh_c = SH_W'(win_id_c) * SH_W'(BITS_W);
  assign win_b_c   = BITS_W'(req_bits >> bits_sh_c);

  always_comb begin
    rr_inc_c = SUM_W'(grant_q.id) + SUM_W'(1);
    if (rr_inc_c >= SUM_W'(NUM_REQ)) rr_inc_c = '0;
  end

  // Next-state and output decode; a seed load aborts any draw.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    step_c   = 1'b0;
    ack_d    = 1'b0;
    ack_id_d = ack_id;
    rand_d   = rand_out;

    if (seed_load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_c) begin
            grant_d = '{id: win_id_c, b: win_b_c};
            cnt_d   = CNT_W'(STEPS);
            state_d = ADVANCE;
          end
        end
        ADVANCE: begin
          step_c = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            if (!reject_c) begin
              rand_d   = masked_c;
              ack_d    = 1'b1;
              ack_id_d = grant_q.id;
              state_d  = RESP;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          rr_d    = ID_W'(rr_inc_c);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      ack      <= 1'b0;
      ack_id   <= '0;
      rand_out <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      ack      <= ack_d;
      ack_id   <= ack_id_d;
      rand_out <= rand_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: doc/rand_arbiter.md
# rand_arbiter

Shares one 32-bit maximal-length LFSR among `NUM_REQ` requesters, such as game logic needing random spawn positions or timers. Each requester raises a request with a range width. The block arbitrates round-robin, advances the LFSR a fixed number of steps to decorrelate successive draws, then returns a masked value with a one-cycle acknowledge. It also owns seeding and guarantees the LFSR never locks up in the all-zero state.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `STEPS`, 8: LFSR shifts per draw (1..32).
- `clk` in 1: clock, rising edge.
- `clr_n` in 1: asynchronous active-low reset.
- `seed_load` in 1: load `seed_data` into the LFSR this cycle.
- `seed_data` in 32: seed value.
- `req` in `NUM_REQ`: per-requester request, level, held until ack.
- `req_bits` in `5*NUM_REQ`: per-requester field `b`; result mask = (2^(b+1))-1; requester i uses bits [5i+4:5i].
- `ack` out 1: one-cycle pulse, `rand_out` valid.
- `ack_id` out 3: index of the requester being acknowledged.
- `rand_out` out 32: masked random value.
- `busy` out 1: high in any state other than IDLE.

## Operation
- LFSR is Fibonacci, left shift: next = {s[30:0], s[31]^s[21]^s[1]^s[0]}.
- Seed 0 is replaced by 32'h1, so the all-zero lockup state is unreachable.
- FSM states: IDLE, ADVANCE, RESP.
- IDLE: if any `req` is high, grant the first set bit at or after `rr_ptr`, wrapping. Latch the winner's `b` and id. Load step counter = `STEPS`. Go to ADVANCE.
- ADVANCE: shift the LFSR once per cycle and decrement the counter. At 0, register `rand_out` = next LFSR state & mask, then go to RESP.
- RESP: `ack`=1, `ack_id` = granted id. `rr_ptr` = granted id + 1 mod `NUM_REQ`. Go to IDLE.
- `seed_load` has priority in every state:
  - LFSR loaded (with zero substitution).
  - Any in-flight draw is aborted: no ack, go to IDLE.
  - `rr_ptr` is unchanged.
- If `req` drops before ack, the draw still completes and acks; the requester ignores it.
- `req` bits for indices ≥ `NUM_REQ` do not exist; `req_bits` field values 0..31 are all legal.
- The LFSR does not free-run; it shifts only in ADVANCE.

## Timing
- Reset values:
  - `ack`=0, `ack_id`=0, `rand_out`=0, `busy`=0.
  - LFSR=32'h1, `rr_ptr`=0, state IDLE.
- Latency, with `req` rising in cycle 0 while IDLE:
  - ADVANCE occupies cycles 1..`STEPS`.
  - `ack` is high in cycle `STEPS`+1.
- Throughput: the FSM always returns to IDLE after RESP, so one draw per `STEPS`+2 cycles.
- A `seed_load` in cycle n is visible in the LFSR from cycle n+1. A draw granted in cycle n+1 uses the new seed.
- Reset asserted mid-draw returns everything to reset values asynchronously; no ack is produced.

## Configuration
- `RAND_ZERO_SKIP_EN` defined: in the final ADVANCE step, a masked result of 0 is rejected. The FSM stays in ADVANCE, shifting one extra step per cycle until the masked result is non-zero. Each rejection adds one cycle of latency, and `rand_out` is never 0.
- Undefined: a masked result of 0 is returned normally with fixed latency `STEPS`+1.

## Structure
- Shared package `rand_pkg`:
  - FSM state enum.
  - Tap positions.
  - Zero-seed substitute 32'h1.
  - Width of `ack_id` (3).
- Sub-module `lfsr32_core`:
  - Ports: `clk`, `clr_n`, `step`, `load`, `load_data`, `state`.
  - Performs zero substitution on load.
- Arbiter and FSM stay in `rand_arbiter`.

## Test plan
- Base draw: reset, `STEPS`=1, `seed_load` 32'h1, `req[0]`=1 with b=31 → `ack` in cycle 2, `ack_id`=0, `rand_out`=32'h3. Second draw → 32'h6.
- Zero seed: seed 32'h0, `STEPS`=1, b=31 → LFSR reads 32'h1, first draw returns 32'h3.
- Round-robin: `req`=4'b1111 held, acks consumed → `ack_id` sequence 0,1,2,3,0. Then `req`=4'b1010 with `rr_ptr`=1 → 1,3,1.
- Abort on seed: `seed_load` in the 3rd ADVANCE cycle with `STEPS`=8 → no ack, `busy`=0 next cycle. The held request re-grants, and ack arrives 8+1 cycles after the re-grant.
- Zero skip: seed 32'h3, `STEPS`=1, b=0:
  - Macro defined: ack at cycle 3 with `rand_out`=1 (LFSR 32'hD).
  - Macro undefined: ack at cycle 2 with `rand_out`=0.
- Reset mid-draw: `clr_n` low during ADVANCE → all outputs 0, LFSR 32'h1. A new request after release behaves as in the base draw.
